pulse_sync_tx: RTL and testbench



---
 rtl/pulse_sync_pkg.sv | 12 +
 rtl/sync_ff.sv | 25 ++
 rtl/pulse_sync_tx.sv | 136 +++++++++++++
 tb/tb_pulse_sync_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the toggle-based pulse-crossing handshake (tx and rx sides).
package pulse_sync_pkg;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned PEND_W_DEF      = 4;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_e;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-low reset.
// STAGES must be at least 2.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_tx.sv
// Transmit side of the toggle pulse-crossing handshake.
// Optional feature macro: PULSE_SYNC_TX_PENDING_EN builds the pending-event counter;
// without it, events arriving during a transfer are dropped.
module pulse_sync_tx
   import pulse_sync_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned PEND_W      = PEND_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   input  logic              ack_tgl,
   output logic              req_tgl,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              drop,
   output logic              err
);

   state_e state_q, state_d;
   logic   req_q, req_d;
   logic   busy_q, busy_d;
   logic   drop_q, drop_d;
   logic   err_q, err_d;
   logic   ack_prev_q;
   logic   ack_sync;
   logic   done;
   logic   launch;
   logic   pend_nz;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_tgl),
      .q   (ack_sync)
   );

   // Transfer completes once the returned toggle catches up with ours
   assign done = (ack_sync == req_q);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (pulse_in || pend_nz) state_d = WAIT_ACK;
         WAIT_ACK: if (done) state_d = IDLE;
      endcase
   end

   // Launch, busy and spurious-ack detection
   always_comb begin
      launch = (state_q == IDLE) && (pulse_in || pend_nz);
      req_d  = req_q ^ launch;
      busy_d = (state_d == WAIT_ACK);
      // The ack toggle must stay still while nothing is in flight
      err_d  = err_q | ((state_q == IDLE) && (ack_sync != ack_prev_q));
   end

   // Output and bookkeeping registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_prev_q <= 1'b0;
      end else begin
         req_q      <= req_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         ack_prev_q <= ack_sync;
      end
   end

`ifdef PULSE_SYNC_TX_PENDING_EN
   logic [PEND_W-1:0] pend_q, pend_d;

   assign pend_nz = |pend_q;

   // Queue events that arrive mid-transfer; a fresh pulse in IDLE takes priority
   // over the queue, so the queue only drains on cycles without a new pulse
   always_comb begin
      pend_d = pend_q;
      drop_d = 1'b0;
      if (state_q == WAIT_ACK) begin
         if (pulse_in) begin
            if (&pend_q) begin
               drop_d = 1'b1;
            end else begin
               pend_d = pend_q + PEND_W'(1);
            end
         end
      end else if (!pulse_in && pend_nz) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   // Pending counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pending = pend_q;
`else
   assign pend_nz = 1'b0;
   assign pending = '0;

   // Without a queue every event during a transfer is lost
   always_comb begin
      drop_d = (state_q == WAIT_ACK) && pulse_in;
   end
`endif

   assign req_tgl = req_q;
   assign busy    = busy_q;
   assign drop    = drop_q;
   assign err     = err_q;

endmodule

// File: tb/tb_pulse_sync_tx.sv
// Directed bench for pulse_sync_tx with a 5-cycle loopback of req_tgl onto ack_tgl.
// Expectations follow PULSE_SYNC_TX_PENDING_EN when it is defined for the build.
module tb_pulse_sync_tx;

   localparam int unsigned PW = 2;
`ifdef PULSE_SYNC_TX_PENDING_EN
   localparam bit PEND_EN = 1'b1;
`else
   localparam bit PEND_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pulse_in = 1'b0;
   logic          ack_flip = 1'b0;
   logic          ack_tgl;
   logic          req_tgl;
   logic          busy;
   logic [PW-1:0] pending;
   logic          drop;
   logic          err;
   logic [4:0]    dly;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_req  = 1'b0;

   int unsigned sat_pend [5] = '{1, 2, 3, 3, 3};
   int unsigned sat_drop [5] = '{0, 0, 0, 1, 1};

   always #5 clk = ~clk;

   // Destination model: returns req_tgl five cycles later, reset with the system
   always_ff @(posedge clk) begin
      if (!rst) begin
         dly <= '0;
      end else begin
         dly <= {dly[3:0], req_tgl};
      end
   end

   assign ack_tgl = dly[4] ^ ack_flip;

   pulse_sync_tx #(
      .SYNC_STAGES (2),
      .PEND_W      (PW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .ack_tgl  (ack_tgl),
      .req_tgl  (req_tgl),
      .busy     (busy),
      .pending  (pending),
      .drop     (drop),
      .err      (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " req_tgl"}, 32'(req_tgl), 32'(0));
      check({tag, " busy"}, 32'(busy), 32'(0));
      check({tag, " pending"}, 32'(pending), 32'(0));
      check({tag, " drop"}, 32'(drop), 32'(0));
      check({tag, " err"}, 32'(err), 32'(0));
   endtask

   task automatic wait_idle(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!busy) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, " idle timeout"}, 32'(seen), 32'(1));
   endtask

   task automatic launch(input string tag);
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      exp_req  = ~exp_req;
      check({tag, " launch req"}, 32'(req_tgl), 32'(exp_req));
      check({tag, " launch busy"}, 32'(busy), 32'(1));
   endtask

`ifdef PULSE_SYNC_TX_PENDING_EN
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         exp_req = ~exp_req;
         check("drain req", 32'(req_tgl), 32'(exp_req));
         check("drain pending", 32'(pending), 32'(n - 1 - i));
         wait_idle("drain");
      end
   endtask
`endif

   initial begin
      // Reset state
      rst = 1'b0;
      repeat (2) tick();
      check_all("reset");
      rst = 1'b1;

      // Single pulse: busy holds for 7 edges after launch, falls on the 8th
      launch("t1");
      check("t1 pending", 32'(pending), 32'(0));
      repeat (7) tick();
      check("t1 busy before match", 32'(busy), 32'(1));
      tick();
      check("t1 busy fall", 32'(busy), 32'(0));
      check("t1 req", 32'(req_tgl), 32'(exp_req));
      check("t1 err", 32'(err), 32'(0));

      // Pulse on the edge busy falls is still a WAIT_ACK pulse
      launch("t4a");
      repeat (7) tick();
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      check("t4a busy fall", 32'(busy), 32'(0));
      check("t4a pending", 32'(pending), 32'(PEND_EN ? 1 : 0));
      check("t4a drop", 32'(drop), 32'(PEND_EN ? 0 : 1));
      tick();
      if (PEND_EN) exp_req = ~exp_req;
      check("t4a drop clear", 32'(drop), 32'(0));
      check("t4a queued req", 32'(req_tgl), 32'(exp_req));
      check("t4a queued busy", 32'(busy), 32'(PEND_EN ? 1 : 0));
      check("t4a pending drained", 32'(pending), 32'(0));
      wait_idle("t4a");

      // Pulse one cycle after busy falls launches directly
      launch("t4b");
      check("t4b pending", 32'(pending), 32'(0));
      wait_idle("t4b");

      // Three pulses during a transfer
      launch("t2");
      for (int i = 0; i < 3; i++) begin
         pulse_in = 1'b1;
         tick();
         check("t2 pending", 32'(pending), 32'(PEND_EN ? i + 1 : 0));
         check("t2 drop", 32'(drop), 32'(PEND_EN ? 0 : 1));
      end
      pulse_in = 1'b0;
      wait_idle("t2");
      check("t2 pending at idle", 32'(pending), 32'(PEND_EN ? 3 : 0));
`ifdef PULSE_SYNC_TX_PENDING_EN
      drain(3);
`endif
      check("t2 final req", 32'(req_tgl), 32'(exp_req));
      check("t2 final pending", 32'(pending), 32'(0));

      // Five pulses during a transfer saturate a 2-bit counter
      launch("sat");
      for (int i = 0; i < 5; i++) begin
         pulse_in = 1'b1;
         tick();
         check("sat pending", 32'(pending), PEND_EN ? sat_pend[i] : 32'(0));
         check("sat drop", 32'(drop), PEND_EN ? sat_drop[i] : 32'(1));
      end
      pulse_in = 1'b0;
      tick();
      check("sat drop clear", 32'(drop), 32'(0));
      wait_idle("sat");
`ifdef PULSE_SYNC_TX_PENDING_EN
      drain(3);
`endif
      check("sat final pending", 32'(pending), 32'(0));

      // Reset in the middle of a transfer with queued events
      launch("rmid");
      pulse_in = 1'b1;
      repeat (2) tick();
      pulse_in = 1'b0;
      check("rmid pending", 32'(pending), 32'(PEND_EN ? 2 : 0));
      rst = 1'b0;
      tick();
      check_all("rmid reset");
      exp_req = 1'b0;
      rst = 1'b1;
      repeat (12) tick();
      check("rmid req quiet", 32'(req_tgl), 32'(0));
      check("rmid busy quiet", 32'(busy), 32'(0));
      check("rmid pending quiet", 32'(pending), 32'(0));

      // Spurious acknowledgement while idle
      ack_flip = 1'b1;
      repeat (2) tick();
      check("spur err early", 32'(err), 32'(0));
      tick();
      check("spur err set", 32'(err), 32'(1));
      repeat (4) tick();
      check("spur err sticky", 32'(err), 32'(1));
      check("spur busy", 32'(busy), 32'(0));
      rst      = 1'b0;
      ack_flip = 1'b0;
      tick();
      check("spur err reset", 32'(err), 32'(0));
      rst = 1'b1;
      repeat (4) tick();
      check("spur err after reset", 32'(err), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
